// File: rtl/fir_tap_mac.sv
// fir_tap_mac: time-multiplexed FIR filter engine.
//
// Each accepted sample is shifted into an NTAPS-deep delay line. The engine
// then spends NTAPS clocks doing one multiply-accumulate per clock against
// the coefficient bank. One more clock saturates the accumulator into
// data_out and pulses out_valid for a single cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, clears all state
//   in_valid   sample_in is valid this cycle
//   in_ready   block can accept a sample this cycle (combinational)
//   sample_in  signed DW-bit input sample
//   coef_wr    coefficient write strobe (honoured only in IDLE without accept)
//   coef_addr  coefficient index to write
//   coef_data  signed DW-bit coefficient value
//   data_out   saturated signed OW-bit result, held until the next result
//   out_valid  one-cycle pulse marking a new data_out
//   busy       high while the engine is in RUN or DONE
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready
// are both high. in_ready depends only on state and reset, never on
// in_valid. A sample offered while in_ready is low is ignored, not queued.
module fir_tap_mac #(
  parameter int NTAPS = 8,
  parameter int DW    = 16,
  parameter int OW    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DW-1:0]      sample_in,
  input  logic                      coef_wr,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic signed [DW-1:0]      coef_data,
  output logic signed [OW-1:0]      data_out,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int IW = $clog2(NTAPS);
  localparam int PW = 2 * DW;
  // The extra IW bits of headroom mean a sum of NTAPS products never wraps.
  localparam int AW = PW + IW;

  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
  localparam logic [IW:0]   NTAPS_W  = NTAPS[IW:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [OW-1:0]  data_out_q, data_out_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [DW-1:0]  d_q [NTAPS];
  logic signed [DW-1:0]  d_d [NTAPS];
  logic signed [DW-1:0]  c_q [NTAPS];
  logic signed [DW-1:0]  c_d [NTAPS];

  logic                  accept;
  logic                  addr_ok;
  logic signed [DW-1:0]  d_sel, c_sel;
  logic signed [PW-1:0]  d_ext, c_ext, prod;
  logic [AW-OW:0]        acc_hi;
  logic                  acc_ovf;
  logic signed [OW-1:0]  acc_sat;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

  assign accept  = in_valid && in_ready;
  assign addr_ok = ({1'b0, coef_addr} < NTAPS_W);

  // Both operands are sign-extended to the full product width so the
  // low PW bits of the multiply hold the exact signed product.
  assign d_sel = d_q[idx_q];
  assign c_sel = c_q[idx_q];
  assign d_ext = {{DW{d_sel[DW-1]}}, d_sel};
  assign c_ext = {{DW{c_sel[DW-1]}}, c_sel};
  assign prod  = d_ext * c_ext;

  // The accumulator fits in OW bits only when every bit from OW-1 upward
  // equals the sign bit; otherwise clamp towards the sign.
  assign acc_hi  = acc_q[AW-1:OW-1];
  assign acc_ovf = !((&acc_hi) || !(|acc_hi));
  assign acc_sat = acc_ovf ? {acc_q[AW-1], {(OW-1){~acc_q[AW-1]}}}
                           : acc_q[OW-1:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    d_d         = d_q;
    c_d         = c_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          d_d[0] = sample_in;
          for (int k = 1; k < NTAPS; k++) begin
            d_d[k] = d_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end else if (coef_wr && addr_ok) begin
          // A write that collides with an accept is dropped on purpose so
          // the coefficient set is stable for the whole computation.
          c_d[coef_addr] = coef_data;
        end
      end
      RUN: begin
        acc_d = acc_q + {{IW{prod[PW-1]}}, prod};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        data_out_d  = acc_sat;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      d_q         <= '{default: '0};
      c_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      c_q         <= c_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed testbench for fir_tap_mac. A second instance with NTAPS = 6
// shares every input with the main instance so that coefficient addresses
// beyond the tap count can be exercised with the same 3-bit address port.
module tb_fir_tap_mac;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] sample_in;
  logic               coef_wr;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic signed [31:0] data_out;
  logic               out_valid;
  logic               busy;

  logic               in_ready6;
  logic signed [31:0] data_out6;
  logic               out_valid6;
  logic               busy6;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  fir_tap_mac #(.NTAPS(8), .DW(16), .OW(32)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sample_in (sample_in),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  fir_tap_mac #(.NTAPS(6), .DW(16), .OW(32)) u_dut6 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready6),
    .sample_in (sample_in),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .data_out  (data_out6),
    .out_valid (out_valid6),
    .busy      (busy6)
  );

  // ---------------- driver tasks ----------------
  // All drivers start and end at 1 time unit after a rising edge.

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    coef_wr  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic signed [15:0] val);
    coef_wr   = 1'b1;
    coef_addr = addr;
    coef_data = val;
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic write_all(input logic signed [15:0] val);
    for (int k = 0; k < 8; k++) write_coef(3'(k), val);
  endtask

  // Offers one sample, then waits (bounded) for the result pulse.
  // lat counts cycles after the accept cycle: cycle 1 follows the accept edge.
  task automatic run_sample(input logic signed [15:0] s, output logic [31:0] res,
                            output int lat, output bit ok);
    int n;
    ok  = 1'b0;
    res = '0;
    lat = 0;
    in_valid  = 1'b1;
    sample_in = s;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 40 && !ok; k++) begin
      if (out_valid) begin
        ok  = 1'b1;
        res = data_out;
        lat = k;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    coef_wr   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    sample_in = 16'sd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (data_out !== 32'sd0) begin
      errors++; $display("FAIL reset_data_out: got %0d expected 0", data_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    logic [31:0] res;
    int lat;
    bit ok;
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(k + 1));
    for (int n = 0; n < 8; n++) begin
      run_sample((n == 0) ? 16'sd1 : 16'sd0, res, lat, ok);
      checks++;
      if (!ok || res !== 32'(n + 1)) begin
        errors++; $display("FAIL impulse_value[%0d]: got %0d (ok=%0b) expected %0d", n, res, ok, n + 1);
      end
      checks++;
      if (lat != 10) begin
        errors++; $display("FAIL impulse_latency[%0d]: got %0d expected 10", n, lat);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] res;
    logic [31:0] r [8];
    int lat;
    bit ok;
    bit all_ok;
    // Positive overflow
    do_reset();
    write_all(16'sd32767);
    all_ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      run_sample(16'sd32767, res, lat, ok);
      r[n] = res;
      all_ok = all_ok && ok;
    end
    checks++;
    if (!all_ok) begin
      errors++; $display("FAIL sat_pos_timeout: got no result pulse expected one per sample");
    end
    checks++;
    if (r[0] !== 32'h3FFF_0001) begin
      errors++; $display("FAIL sat_pos_r1: got %h expected 3fff0001", r[0]);
    end
    checks++;
    if (r[1] !== 32'h7FFE_0002) begin
      errors++; $display("FAIL sat_pos_r2: got %h expected 7ffe0002", r[1]);
    end
    checks++;
    if (r[2] !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL sat_pos_r3: got %h expected 7fffffff", r[2]);
    end
    checks++;
    if (r[7] !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL sat_pos_r8: got %h expected 7fffffff", r[7]);
    end
    // Negative overflow
    do_reset();
    write_all(-16'sd32768);
    all_ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      run_sample(16'sd32767, res, lat, ok);
      r[n] = res;
      all_ok = all_ok && ok;
    end
    checks++;
    if (!all_ok) begin
      errors++; $display("FAIL sat_neg_timeout: got no result pulse expected one per sample");
    end
    checks++;
    if (r[0] !== 32'hC000_8000) begin
      errors++; $display("FAIL sat_neg_r1: got %h expected c0008000", r[0]);
    end
    checks++;
    if (r[1] !== 32'h8001_0000) begin
      errors++; $display("FAIL sat_neg_r2: got %h expected 80010000", r[1]);
    end
    checks++;
    if (r[7] !== 32'h8000_0000) begin
      errors++; $display("FAIL sat_neg_r8: got %h expected 80000000", r[7]);
    end
  endtask

  task automatic test_back_to_back();
    int ready_cnt = 0;
    int ov_cnt = 0;
    int gap_err = 0;
    int coin_err = 0;
    int busy_err = 0;
    int last_ready = -1;
    do_reset();
    write_all(16'sd2);
    in_valid  = 1'b1;
    sample_in = 16'sd100;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (in_ready !== !busy) busy_err++;
      if (in_ready) begin
        ready_cnt++;
        if (last_ready >= 0 && cyc - last_ready != 10) gap_err++;
        if (ready_cnt > 1 && !out_valid) coin_err++;
        last_ready = cyc;
      end
      if (out_valid) begin
        ov_cnt++;
        if (!in_ready) coin_err++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    // The final accept (cycle 40) reports its result now, in cycle 50.
    if (out_valid) ov_cnt++;
    checks++;
    if (ready_cnt != 5) begin
      errors++; $display("FAIL b2b_ready_count: got %0d expected 5", ready_cnt);
    end
    checks++;
    if (ov_cnt != 5) begin
      errors++; $display("FAIL b2b_out_valid_count: got %0d expected 5", ov_cnt);
    end
    checks++;
    if (gap_err != 0) begin
      errors++; $display("FAIL b2b_ready_period: got %0d bad gaps expected 0", gap_err);
    end
    checks++;
    if (coin_err != 0) begin
      errors++; $display("FAIL b2b_accept_with_out_valid: got %0d misaligned expected 0", coin_err);
    end
    checks++;
    if (busy_err != 0) begin
      errors++; $display("FAIL b2b_busy_vs_ready: got %0d bad cycles expected 0", busy_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] res;
    int lat;
    bit ok;
    int ov_seen = 0;
    do_reset();
    write_all(16'sd3);
    run_sample(16'sd5, res, lat, ok);
    checks++;
    if (!ok || res !== 32'd15) begin
      errors++; $display("FAIL midrun_pre_result: got %0d (ok=%0b) expected 15", res, ok);
    end
    in_valid  = 1'b1;
    sample_in = 16'sd7;
    @(posedge clk); #1;              // accept edge, now in RUN cycle 1
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;              // RUN cycle 4
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL midrun_in_ready_in_reset: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) ov_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (ov_seen != 0) begin
      errors++; $display("FAIL midrun_out_valid: got %0d pulses expected 0", ov_seen);
    end
    checks++;
    if (data_out !== 32'sd0) begin
      errors++; $display("FAIL midrun_data_out: got %0d expected 0", data_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midrun_busy: got %b expected 0", busy);
    end
    // Coefficients were cleared: filling every tap still gives zero.
    for (int n = 0; n < 8; n++) begin
      run_sample(16'sd9, res, lat, ok);
      checks++;
      if (!ok || res !== 32'd0) begin
        errors++; $display("FAIL midrun_cleared_coef[%0d]: got %0d (ok=%0b) expected 0", n, res, ok);
      end
    end
  endtask

  task automatic test_write_in_run();
    logic [31:0] res;
    int lat;
    bit ok;
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(k + 1));
    in_valid  = 1'b1;
    sample_in = 16'sd1;
    @(posedge clk); #1;              // accept edge
    in_valid  = 1'b0;
    coef_wr   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd100;
    @(posedge clk); #1;              // write offered during RUN
    coef_wr = 1'b0;
    ok  = 1'b0;
    res = '0;
    for (int k = 0; k < 30 && !ok; k++) begin
      if (out_valid) begin
        ok  = 1'b1;
        res = data_out;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!ok || res !== 32'd1) begin
      errors++; $display("FAIL run_write_first: got %0d (ok=%0b) expected 1", res, ok);
    end
    // Delay line now 1,1,0..: c0 + c1 = 3 if c0 kept its old value.
    run_sample(16'sd1, res, lat, ok);
    checks++;
    if (!ok || res !== 32'd3) begin
      errors++; $display("FAIL run_write_second: got %0d (ok=%0b) expected 3", res, ok);
    end
  endtask

  task automatic test_collision();
    logic [31:0] res;
    int lat;
    bit ok;
    do_reset();
    write_coef(3'd0, 16'sd2);
    in_valid  = 1'b1;
    sample_in = 16'sd1;
    coef_wr   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd5;
    @(posedge clk); #1;              // accept and write on the same edge
    in_valid = 1'b0;
    coef_wr  = 1'b0;
    ok  = 1'b0;
    res = '0;
    for (int k = 0; k < 30 && !ok; k++) begin
      if (out_valid) begin
        ok  = 1'b1;
        res = data_out;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!ok || res !== 32'd2) begin
      errors++; $display("FAIL collision_result: got %0d (ok=%0b) expected 2", res, ok);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (data_out !== 32'sd2 || out_valid !== 1'b0) begin
      errors++; $display("FAIL collision_hold: got %0d valid %b expected 2 valid 0", data_out, out_valid);
    end
  endtask

  task automatic test_out_of_range();
    int cnt6 = 0;
    int exp6 = 0;
    logic [31:0] last6;
    do_reset();
    for (int k = 0; k < 6; k++) write_coef(3'(k), 16'(k + 1));
    // Addresses 6 and 7 do not exist in the 6-tap instance.
    write_coef(3'd6, 16'sd1000);
    write_coef(3'd7, 16'sd1000);
    checks++;
    if (data_out6 !== 32'sd0 || out_valid6 !== 1'b0 || in_ready6 !== 1'b1 || busy6 !== 1'b0) begin
      errors++; $display("FAIL oor_outputs_after_write: got data %0d valid %b ready %b busy %b expected 0 0 1 0",
                         data_out6, out_valid6, in_ready6, busy6);
    end
    for (int n = 0; n < 6; n++) begin
      in_valid  = 1'b1;
      sample_in = 16'sd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      last6 = 'x;
      cnt6  = 0;
      for (int k = 1; k < 12; k++) begin
        if (out_valid6) begin
          cnt6++;
          last6 = data_out6;
        end
        @(posedge clk); #1;
      end
      exp6 = exp6 + n + 1;
      checks++;
      if (cnt6 != 1 || last6 !== 32'(exp6)) begin
        errors++; $display("FAIL oor_sum[%0d]: got %0d (pulses %0d) expected %0d", n, last6, cnt6, exp6);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_back_to_back();
    test_reset_mid_run();
    test_write_in_run();
    test_collision();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
